// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU operand/opcode interface: issues one command to a registered ALU,
// waits its latency and returns the masked result with the command tag. Option: ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
    parameter int unsigned NUMBITS     = 32,
    parameter int unsigned TAGBITS     = 4,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUMBITS-1:0] cmd_a,
    input  logic [NUMBITS-1:0] cmd_b,
    input  logic [2:0]         cmd_op,
    input  logic [TAGBITS-1:0] cmd_tag,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic               cmd_chain,
`endif
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic [TAGBITS-1:0] rsp_tag,
    output logic               busy,
    output logic [15:0]        op_count
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned COUNT_W = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SADD = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SSUB = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [TAGBITS-1:0] tag_q;
    logic [NUMBITS-1:0] a_sel;

`ifdef ALU_SEQ_CHAIN_EN
    logic [NUMBITS-1:0] last_result;

    // Chained commands take operand A from the previous completed result
    always_comb begin
        a_sel = cmd_a;
        if (cmd_chain) begin
            a_sel = last_result;
        end
    end
`else
    always_comb begin
        a_sel = cmd_a;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            wait_cnt     <= '0;
            tag_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_tag      <= '0;
            op_count     <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            last_result  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready rises one edge after reset release, then stays up while idle
                    if (cmd_ready && cmd_valid) begin
                        alu_a      <= a_sel;
                        alu_b      <= cmd_b;
                        alu_opcode <= cmd_op;
                        tag_q      <= cmd_tag;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CNT_W'(ALU_LATENCY - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_result   <= alu_result;
                        rsp_carry    <= alu_carryout && ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB));
                        rsp_overflow <= alu_overflow && ((alu_opcode == OP_SADD) || (alu_opcode == OP_SSUB));
                        rsp_zero     <= alu_zero;
                        rsp_tag      <= tag_q;
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + COUNT_W'(1);
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
`ifdef ALU_SEQ_CHAIN_EN
                        last_result <= rsp_result;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with behavioural registered ALUs at latency 1 and 3.
module tb_alu_op_sequencer;

    localparam int unsigned NB = 32;
    localparam int unsigned TB = 4;

    typedef logic [NB+1:0] alu_out_t;   // {carry, overflow, result}
    typedef struct packed {
        logic [TB-1:0] tag;
        logic          z;
        logic          v;
        logic          c;
        logic [NB-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, force_flags;
    logic          cmd_valid, cmd_valid3, cmd_chain, cmd_chain3;
    logic [NB-1:0] cmd_a, cmd_b;
    logic [2:0]    cmd_op;
    logic [TB-1:0] cmd_tag;
    logic          rsp_ready, rsp_ready3;

    logic          cmd_ready, busy, rsp_valid, rsp_carry, rsp_overflow, rsp_zero;
    logic [NB-1:0] alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]    alu_opcode;
    logic          alu_carryout, alu_overflow, alu_zero;
    logic [TB-1:0] rsp_tag;
    logic [15:0]   op_count;

    logic          cmd_ready3, busy3, rsp_valid3, rsp_carry3, rsp_overflow3, rsp_zero3;
    logic [NB-1:0] alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [2:0]    alu_opcode3;
    logic          alu_carryout3, alu_overflow3, alu_zero3;
    logic [TB-1:0] rsp_tag3;
    logic [15:0]   op_count3;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic alu_out_t alu_fn(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [2:0] op);
        logic [NB:0]   s;
        logic [NB-1:0] r;
        logic          c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            3'd0, 3'd1: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[NB-1:0];
                c = s[NB];
                v = (a[NB-1] == b[NB-1]) && (r[NB-1] != a[NB-1]);
            end
            3'd2, 3'd3: begin
                r = a - b;
                c = (a < b);
                v = (a[NB-1] != b[NB-1]) && (r[NB-1] != a[NB-1]);
            end
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = a ^ b;
            default: begin
                r = {a[NB-2:0], 1'b0};
                c = a[NB-1];
            end
        endcase
        return {c, v, r};
    endfunction

    function automatic exp_t exp_fn(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                    input logic [2:0] op, input logic [TB-1:0] tag);
        alu_out_t o;
        exp_t     e;
        o     = alu_fn(a, b, op);
        e.r   = o[NB-1:0];
        e.c   = o[NB+1] && (op == 3'd0 || op == 3'd2);
        e.v   = o[NB] && (op == 3'd1 || op == 3'd3);
        e.z   = (e.r == '0);
        e.tag = tag;
        return e;
    endfunction

    // Registered ALU models
    alu_out_t p1;
    alu_out_t p3 [3];
    always_ff @(posedge clk) begin
        p1    <= alu_fn(alu_a, alu_b, alu_opcode);
        p3[0] <= alu_fn(alu_a3, alu_b3, alu_opcode3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign alu_result    = p1[NB-1:0];
    assign alu_zero      = (p1[NB-1:0] == '0);
    assign alu_carryout  = p1[NB+1] | force_flags;
    assign alu_overflow  = p1[NB] | force_flags;
    assign alu_result3   = p3[2][NB-1:0];
    assign alu_zero3     = (p3[2][NB-1:0] == '0);
    assign alu_carryout3 = p3[2][NB+1];
    assign alu_overflow3 = p3[2][NB];

    alu_op_sequencer #(.NUMBITS(NB), .TAGBITS(TB), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .alu_carryout(alu_carryout), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.NUMBITS(NB), .TAGBITS(TB), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain3),
`endif
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_result(alu_result3),
        .alu_carryout(alu_carryout3), .alu_overflow(alu_overflow3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_carry(rsp_carry3), .rsp_overflow(rsp_overflow3), .rsp_zero(rsp_zero3),
        .rsp_tag(rsp_tag3), .busy(busy3), .op_count(op_count3)
    );

    // Scoreboard: push on command handshake, pop and compare on response handshake
    exp_t          q1[$];
    exp_t          q3[$];
    logic [NB-1:0] last_exp;

    always @(negedge clk) begin
        exp_t          e;
        logic [NB-1:0] a_eff;
        if (reset !== 1'b1) begin
            q1.delete();
            q3.delete();
            last_exp = '0;
        end else begin
            a_eff = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
            if (cmd_chain) a_eff = last_exp;
`endif
            if (cmd_valid && cmd_ready) q1.push_back(exp_fn(a_eff, cmd_b, cmd_op, cmd_tag));
            if (cmd_valid3 && cmd_ready3) q3.push_back(exp_fn(cmd_a, cmd_b, cmd_op, cmd_tag));
            if (rsp_valid && rsp_ready) begin
                if (q1.size() == 0) check_eq("rsp_unexpected", 64'(1), 64'(0));
                else begin
                    e = q1.pop_front();
                    check_eq("rsp_result", 64'(rsp_result), 64'(e.r));
                    check_eq("rsp_zvc", 64'({rsp_zero, rsp_overflow, rsp_carry}), 64'({e.z, e.v, e.c}));
                    check_eq("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    last_exp = e.r;
                end
            end
            if (rsp_valid3 && rsp_ready3) begin
                if (q3.size() == 0) check_eq("rsp3_unexpected", 64'(1), 64'(0));
                else begin
                    e = q3.pop_front();
                    check_eq("rsp3_result", 64'(rsp_result3), 64'(e.r));
                    check_eq("rsp3_zvc", 64'({rsp_zero3, rsp_overflow3, rsp_carry3}), 64'({e.z, e.v, e.c}));
                    check_eq("rsp3_tag", 64'(rsp_tag3), 64'(e.tag));
                end
            end
        end
    end

    // exp_lat counts edges from the accept edge (inclusive) to rsp_valid high; 0 skips the measurement
    task automatic send(input bit sel3, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [2:0] op, input logic [TB-1:0] tag, input bit chain, input int exp_lat);
        bit ok;
        int n;
        @(posedge clk); #1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_chain = chain;
        if (sel3) cmd_valid3 = 1'b1;
        else cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel3 ? cmd_ready3 : cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        if (!ok) begin
            check_eq("accept_timeout", 64'(0), 64'(1));
            return;
        end
        if (exp_lat != 0) begin
            n  = 1;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (sel3 ? rsp_valid3 : rsp_valid) begin ok = 1'b1; break; end
                @(posedge clk);
                n++;
            end
            check_eq("latency", 64'(ok ? n : -1), 64'(exp_lat));
        end
    endtask

    task automatic wait_idle(input bit sel3);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(sel3 ? busy3 : busy)) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [NB-1:0] ta [7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7, 32'h0, 32'hF0F0, 32'hAAAA5555, 32'h80000001};
    logic [NB-1:0] tbv[7] = '{32'h1, 32'h1, 32'h5, 32'h1, 32'hFF00, 32'hFFFF0000, 32'h0};
    logic [2:0]    top[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

    initial begin
        bit seen;
        reset = 1'b0; force_flags = 1'b0;
        cmd_valid = 1'b1; cmd_valid3 = 1'b0; cmd_chain = 1'b0; cmd_chain3 = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b1; rsp_ready3 = 1'b1;

        // Reset with a command pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("reset_op_count", 64'(op_count), 64'(0));
        check_eq("reset_alu_a", 64'(alu_a), 64'(0));
        @(posedge clk); #1 reset = 1'b1; cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("post_busy", 64'(busy), 64'(0));

        // Add with carry out and zero result
        send(0, 32'hFFFFFFFF, 32'h1, 3'd0, 4'd3, 0, 3);
        wait_idle(0);

        // OR with forced ALU flags: both masked
        force_flags = 1'b1;
        send(0, 32'hF0F00000, 32'h0000000F, 3'd5, 4'd1, 0, 3);
        wait_idle(0);
        force_flags = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send(0, ta[i], tbv[i], top[i], 4'(i + 8), 0, 3);
            wait_idle(0);
        end

        // Back-pressure with a second command waiting
        pulse_reset();
        rsp_ready = 1'b0;
        send(0, 32'h5, 32'h7, 3'd2, 4'd4, 0, 3);
        @(posedge clk); #1;
        cmd_a = 32'h9; cmd_b = 32'h6; cmd_op = 3'd6; cmd_tag = 4'd5; cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            check_eq("hold_rsp_result", 64'(rsp_result), 64'(32'hFFFFFFFE));
            check_eq("hold_rsp_carry", 64'(rsp_carry), 64'(1));
            check_eq("hold_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_op_count", 64'(op_count), 64'(1));
        check_eq("bp_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("bp_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_second_busy", 64'(busy), 64'(1));
        wait_idle(0);
        check_eq("bp_op_count2", 64'(op_count), 64'(2));

        // Reset during WAIT discards the operation
        send(0, 32'h1, 32'h2, 3'd0, 4'd6, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        check_eq("abort_no_rsp", 64'(seen), 64'(0));
        check_eq("abort_op_count", 64'(op_count), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_cmd_ready", 64'(cmd_ready), 64'(1));

        // Reset coinciding with a response handshake
        send(0, 32'h10, 32'h20, 3'd0, 4'd2, 0, 3);
        wait_idle(0);
        rsp_ready = 1'b0;
        send(0, 32'h3, 32'h4, 3'd0, 4'd7, 0, 3);
        @(posedge clk); #1 rsp_ready = 1'b1; reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rst_hs_op_count", 64'(op_count), 64'(0));
        check_eq("rst_hs_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);

        // Latency 3: signed subtract overflow
        send(1, 32'h80000000, 32'h1, 3'd3, 4'd9, 0, 5);
        wait_idle(1);
        check_eq("lat3_op_count", 64'(op_count3), 64'(1));

`ifdef ALU_SEQ_CHAIN_EN
        pulse_reset();
        send(0, 32'h5, 32'h3, 3'd0, 4'd1, 0, 3);
        wait_idle(0);
        send(0, 32'hFFFF, 32'h2, 3'd0, 4'd2, 1, 3);
        wait_idle(0);
        check_eq("chain_add", 64'(rsp_result), 64'(32'hA));
        send(0, 32'h0, 32'h0, 3'd7, 4'd3, 1, 3);
        wait_idle(0);
        check_eq("chain_shl", 64'(rsp_result), 64'(32'h14));
`endif

        check_eq("sb_empty", 64'(q1.size() + q3.size()), 64'(0));
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
